// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
// The memory-side FSM states and the queue entry layout live here.
package fetch_pkg;

   localparam int FETCH_PC_W    = 16;
   localparam int FETCH_INSTR_W = 16;
   localparam int FETCH_DEPTH   = 4;
   localparam int FETCH_PC_INC  = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT      = 2'd1,
      WAIT_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instr} with push, pop and a flush.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  PC_W    = FETCH_PC_W,
   parameter int  INSTR_W = FETCH_INSTR_W,
   parameter int  DEPTH   = FETCH_DEPTH,
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [PC_W-1:0]    push_pc_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   output logic [PC_W-1:0]    head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic [CW-1:0]      count_o
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~flush_i & (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= '{pc: push_pc_i, instr: push_instr_i};
   end

   assign head_pc_o    = mem_q[rd_ptr_q].pc;
   assign head_instr_o = mem_q[rd_ptr_q].instr;
   assign count_o      = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC, issues one outstanding request at a time to
// instruction memory, buffers responses and presents them to IF/ID via valid/ready.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W     = FETCH_PC_W,
   parameter int              INSTR_W  = FETCH_INSTR_W,
   parameter int              DEPTH    = FETCH_DEPTH,
   parameter int              PC_INC   = FETCH_PC_INC,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    out_pc_next,
   output logic [PC_W-1:0]    fetch_pc,
   output fetch_state_t       dbg_state
);

   // Handshake: a queue entry transfers on a rising edge where out_valid & out_ready
   // and no redirect; the head fields hold steady while out_valid & ~out_ready.

   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PC_W-1:0] INC_C   = PC_W'(PC_INC);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  req_pc_q, req_pc_d;
   logic [CW-1:0]    count;
   logic [PC_W-1:0]  head_pc;
   logic             push, pop;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      imem_req   = 1'b0;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            // Nothing is outstanding in IDLE, so count < DEPTH reserves the slot.
            imem_req = rst & (count < DEPTH_C) & ~redirect;
            if (imem_req && imem_ack) begin
               state_d    = WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + INC_C;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = IDLE;
               push    = ~redirect;
            end else if (redirect) begin
               state_d = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (imem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (redirect) fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   assign out_valid = rst & (count != '0);
   assign pop       = out_valid & out_ready;

   fetch_fifo #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect),
      .push_i       (push),
      .pop_i        (pop),
      .push_pc_i    (req_pc_q),
      .push_instr_i (imem_rdata),
      .head_pc_o    (head_pc),
      .head_instr_o (out_instr),
      .count_o      (count)
   );

   assign out_pc      = head_pc;
   assign out_pc_next = head_pc + INC_C;
   assign imem_addr   = fetch_pc_q;
   assign fetch_pc    = fetch_pc_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a latency-programmable memory model and an
// expected-PC queue checked at every pop; a second instance covers RESET_PC=0xFFFC.
module tb_fetch_queue_unit;
   import fetch_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        out_ready;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        sel;
   logic        ack_en;
   logic        ack_a, ack_w;

   logic        req_a, req_w, valid_a, valid_w;
   logic [15:0] addr_a, addr_w, instr_a, instr_w, pc_a, pc_w;
   logic [15:0] pcn_a, pcn_w, fpc_a, fpc_w;
   fetch_state_t st_a, st_w;

   assign ack_a = ack_en & ~sel;
   assign ack_w = ack_en & sel;

   fetch_queue_unit u_dut (
      .clk (clk), .rst (rst), .redirect (redirect), .redirect_pc (redirect_pc),
      .imem_req (req_a), .imem_addr (addr_a), .imem_ack (ack_a),
      .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
      .out_valid (valid_a), .out_ready (out_ready), .out_instr (instr_a),
      .out_pc (pc_a), .out_pc_next (pcn_a), .fetch_pc (fpc_a), .dbg_state (st_a)
   );

   fetch_queue_unit #(.RESET_PC (16'hFFFC)) u_dut_wrap (
      .clk (clk), .rst (rst), .redirect (redirect), .redirect_pc (redirect_pc),
      .imem_req (req_w), .imem_addr (addr_w), .imem_ack (ack_w),
      .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
      .out_valid (valid_w), .out_ready (out_ready), .out_instr (instr_w),
      .out_pc (pc_w), .out_pc_next (pcn_w), .fetch_pc (fpc_w), .dbg_state (st_w)
   );

   logic         m_req, m_valid;
   logic [15:0]  m_addr, m_instr, m_pc, m_pcn, m_fpc;
   fetch_state_t m_state;
   assign m_req   = sel ? req_w   : req_a;
   assign m_valid = sel ? valid_w : valid_a;
   assign m_addr  = sel ? addr_w  : addr_a;
   assign m_instr = sel ? instr_w : instr_a;
   assign m_pc    = sel ? pc_w    : pc_a;
   assign m_pcn   = sel ? pcn_w   : pcn_a;
   assign m_fpc   = sel ? fpc_w   : fpc_a;
   assign m_state = sel ? st_w    : st_a;

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- memory model ----------------
   int          lat;
   bit          pend;
   int          cd;
   logic [15:0] paddr;

   task automatic mem_drive();
      imem_rvalid = 1'b0;
      if (pend) begin
         cd--;
         if (cd == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hA000 + paddr;
            pend        = 1'b0;
         end
      end
      if (ack_en && m_req) begin
         pend  = 1'b1;
         paddr = m_addr;
         cd    = lat;
      end
   endtask

   task automatic monitor();
      logic [15:0] e, ei, en;
      if (rst && m_valid && out_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            check_eq("pop_unexpected", {16'h0, m_pc}, 32'hFFFF_FFFF);
         end else begin
            e  = exp_q.pop_front();
            ei = 16'hA000 + e;
            en = e + 16'd2;
            check_eq("pop_pc", m_pc, e);
            check_eq("pop_instr", m_instr, ei);
            check_eq("pop_pc_next", m_pcn, en);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      #1;
      mem_drive();
      #1;
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [15:0] exp_pc);
      rst = 1'b0; redirect = 1'b0; ack_en = 1'b0; out_ready = 1'b0;
      pend = 1'b0; imem_rvalid = 1'b0;
      cycle();
      cycle();
      check_eq("rst_req", m_req, 1'b0);
      check_eq("rst_valid", m_valid, 1'b0);
      check_eq("rst_fetch_pc", m_fpc, exp_pc);
      check_eq("rst_state", m_state, IDLE);
      rst = 1'b1;
      ack_en = 1'b1;
   endtask

   task automatic wait_pops(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         cycle();
      end
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; sel = 1'b0; ack_en = 1'b0;
      lat = 1; pend = 1'b0; cd = 0; paddr = '0;
      @(posedge clk);
      #1;

      // Streaming with 1-cycle memory
      do_reset(16'h0000);
      lat = 1; out_ready = 1'b1;
      exp_q = '{16'h0000, 16'h0002, 16'h0004};
      wait_pops("t1_done", 20);

      // Backpressure fills the queue, then drains in order
      do_reset(16'h0000);
      lat = 1; out_ready = 1'b0;
      repeat (12) cycle();
      check_eq("bp_req_full", m_req, 1'b0);
      check_eq("bp_valid", m_valid, 1'b1);
      check_eq("bp_instr", m_instr, 16'hA000);
      check_eq("bp_pc", m_pc, 16'h0000);
      check_eq("bp_fetch_pc", m_fpc, 16'h0008);
      repeat (3) cycle();
      check_eq("bp_instr_hold", m_instr, 16'hA000);
      check_eq("bp_req_hold", m_req, 1'b0);
      out_ready = 1'b1;
      exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
      wait_pops("t2_done", 30);

      // Redirect while a 3-cycle request is outstanding
      do_reset(16'h0000);
      lat = 3; out_ready = 1'b1;
      cycle();
      check_eq("rd_state_wait", m_state, WAIT);
      check_eq("rd_fetch_pc_inc", m_fpc, 16'h0002);
      redirect = 1'b1; redirect_pc = 16'h0040;
      #1;
      check_eq("rd_req_forced", m_req, 1'b0);
      cycle();
      redirect = 1'b0;
      check_eq("rd_state_drop", m_state, WAIT_DROP);
      check_eq("rd_fetch_pc", m_fpc, 16'h0040);
      check_eq("rd_valid_flushed", m_valid, 1'b0);
      cycle();
      cycle();
      check_eq("rd_state_idle", m_state, IDLE);
      check_eq("rd_stale_dropped", m_valid, 1'b0);
      #1;
      check_eq("rd_req_new", m_req, 1'b1);
      check_eq("rd_addr_new", m_addr, 16'h0040);
      exp_q = '{16'h0040};
      wait_pops("t3_done", 20);

      // Redirect in the same cycle as the response
      do_reset(16'h0000);
      lat = 1; out_ready = 1'b1;
      cycle();
      redirect = 1'b1; redirect_pc = 16'h0080;
      cycle();
      redirect = 1'b0;
      check_eq("rv_state_idle", m_state, IDLE);
      check_eq("rv_not_pushed", m_valid, 1'b0);
      check_eq("rv_fetch_pc", m_fpc, 16'h0080);
      #1;
      check_eq("rv_req", m_req, 1'b1);
      check_eq("rv_addr", m_addr, 16'h0080);
      exp_q = '{16'h0080};
      wait_pops("t4_done", 20);

      // PC wrap from RESET_PC=0xFFFC
      sel = 1'b1;
      do_reset(16'hFFFC);
      lat = 1; out_ready = 1'b1;
      exp_q = '{16'hFFFC, 16'hFFFE, 16'h0000};
      wait_pops("t5_done", 20);
      rst = 1'b0;
      sel = 1'b0;

      // Reset while WAIT; the late response must not be queued
      do_reset(16'h0000);
      lat = 4; out_ready = 1'b1;
      cycle();
      check_eq("rw_state_wait", m_state, WAIT);
      rst = 1'b0;
      #1;
      check_eq("rw_req_in_rst", m_req, 1'b0);
      check_eq("rw_valid_in_rst", m_valid, 1'b0);
      cycle();
      check_eq("rw_state_rst", m_state, IDLE);
      check_eq("rw_fetch_pc_rst", m_fpc, 16'h0000);
      cycle();
      ack_en = 1'b0;
      rst = 1'b1;
      cycle();
      cycle();
      cycle();
      check_eq("rw_late_ignored", m_valid, 1'b0);
      check_eq("rw_state_idle", m_state, IDLE);
      check_eq("rw_fetch_pc", m_fpc, 16'h0000);
      ack_en = 1'b1;
      exp_q = '{16'h0000};
      wait_pops("t6_done", 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
